fetch_stage1: RTL

Controller and two-entry instruction buffer for pipeline stage 1 of the pipelined BPF CPU. It sits directly downstream of the stage-0 fetch controller and captures instruction words returned by instruction memory one cycle after each read. It resolves unconditional jumps (`JA`) locally and holds fetch off while a conditional jump or `RET` is in the pipeline. It presents instructions to stage 2 through a valid/stall handshake. Its `stage1_stalled` and `stage1_PC_en` outputs feed stage 0's stall logic. Its `PC_en`/`PC_sel` are OR'ed with the other stages' outputs at the top level.

---
 rtl/fetch_stage1_if.sv | 22 ++
 rtl/fetch_stage1.sv | 53 +++++
 2 files changed

// File: rtl/fetch_stage1_if.sv
// fetch_stage1_if: stage-0/imem/stage-2 facing signals of fetch stage 1
interface fetch_stage1_if;
  logic        stage0_valid;
  logic [63:0] instr_in;
  logic        stage2_stalled;
  logic        stage2_PC_en;
  logic        stage1_stalled;
  logic        stage1_PC_en;
  logic [1:0]  PC_sel;
  logic [31:0] jump_imm;
  logic        stage1_valid;
  logic [63:0] IR;
  logic        halted;
  modport slave (
    input  stage0_valid, instr_in, stage2_stalled, stage2_PC_en,
    output stage1_stalled, stage1_PC_en, PC_sel, jump_imm, stage1_valid, IR, halted
  );
  modport master (
    output stage0_valid, instr_in, stage2_stalled, stage2_PC_en,
    input  stage1_stalled, stage1_PC_en, PC_sel, jump_imm, stage1_valid, IR, halted
  );
endinterface

// File: rtl/fetch_stage1.sv
// fetch_stage1: two-entry instruction buffer, local JA resolution and fetch hold for branches/RET
module fetch_stage1 (
  input logic            clk,
  input logic            rst,
  fetch_stage1_if.slave  bus
);
  localparam logic [1:0] PC_SEL_PLUS_IMM = 2'b10;
  typedef enum logic [1:0] {RUN, WAIT_BR, HALT} state_t;
  state_t      state_q, state_d;
  logic        inflight_q;
  logic [1:0]  occ_q, occ_d, occ_ad;
  logic [63:0] ir_q, ir_d, skid_q, skid_d;
  logic [15:0] code;
  logic        is_ja, is_cj, is_ret, enq, drain;
  always_comb begin
    code    = bus.instr_in[63:48];
    is_ja   = inflight_q && code == 16'h0005;
    is_cj   = inflight_q && code[2:0] == 3'b101 && !is_ja;
    is_ret  = inflight_q && code[2:0] == 3'b110;
    enq     = inflight_q && !is_ja;
    drain   = occ_q != 2'd0 && !bus.stage2_stalled;
    occ_ad  = occ_q - {1'b0, drain};
    occ_d   = occ_ad + {1'b0, enq};
    ir_d    = enq && occ_ad == 2'd0 ? bus.instr_in : drain ? skid_q : ir_q;
    skid_d  = enq && occ_ad != 2'd0 ? bus.instr_in : skid_q;
    state_d = state_q == RUN     ? (is_cj ? WAIT_BR : is_ret ? HALT : RUN) :
              state_q == WAIT_BR ? (bus.stage2_PC_en ? RUN : WAIT_BR) : HALT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      ir_q       <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= bus.stage0_valid;
      occ_q      <= occ_d;
      ir_q       <= ir_d;
      skid_q     <= skid_d;
    end
  end
  assign bus.stage1_PC_en   = state_q == RUN && is_ja;
  assign bus.PC_sel         = bus.stage1_PC_en ? PC_SEL_PLUS_IMM : 2'b00;
  assign bus.jump_imm       = bus.instr_in[31:0];
  assign bus.stage1_valid   = occ_q != 2'd0;
  assign bus.IR             = ir_q;
  assign bus.halted         = state_q == HALT;
  // CJMP/RET arrivals also hold fetch so no wrong-path word follows them
  assign bus.stage1_stalled = state_q != RUN || is_ja || is_cj || is_ret || occ_q == 2'd2 ||
                              (occ_q == 2'd1 && inflight_q && bus.stage2_stalled);
endmodule
